bcd_scan_display: RTL and testbench

- Time-multiplexed 7-segment display driver. It is the downstream consumer of the decade counter chain.
- Takes N_DIGITS packed BCD digits, snapshots them once per scan frame to prevent tearing, and drives one digit at a time.
- Provides segment decode, one-hot digit select and optional leading-zero blanking.
- Sits between the MOD-10 counter outputs and the board display pins.

---
 rtl/bcd_scan_display.sv | 112 +++++++++++
 tb/tb_bcd_scan_display.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - time-multiplexed 7-segment BCD display driver
// Snapshots the digits once per scan frame and drives one digit per prescale slot.
module bcd_scan_display #(
   parameter int N_DIGITS       = 4,
   parameter int PRESCALE       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    en,
   input  logic [4*N_DIGITS-1:0]   bcd_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_start
);

   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int PRE_W = $clog2(PRESCALE);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0]      pre_cnt;
   logic [IDX_W-1:0]      idx;
   logic [4*N_DIGITS-1:0] snapshot;
   logic                  primed;
   logic [6:0]            seg_q;
   logic [N_DIGITS-1:0]   an_q;
   logic                  fs_q;

   logic                  pre_wrap;
   logic                  load;
   logic                  zero_above;
   logic [3:0]            cur_digit;
   logic [N_DIGITS-1:0]   blank_vec;
   logic [6:0]            seg_d;
   logic [N_DIGITS-1:0]   an_d;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   // Snapshot loads on the first enabled cycle after reset and on each frame wrap.
   always_comb begin
      pre_wrap = (pre_cnt == PRE_MAX);
      load     = en && (!primed || (pre_wrap && (idx == IDX_MAX)));
   end

   always_comb begin
      zero_above = 1'b1;
      blank_vec  = '0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         zero_above   = zero_above & (snapshot[4*k +: 4] == 4'd0);
         blank_vec[k] = blank_lz & zero_above;
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx == IDX_W'(k)) cur_digit = snapshot[4*k +: 4];
      end
      an_d  = '0;
      seg_d = '0;
      if (en && !blank_vec[idx]) begin
         an_d[idx] = 1'b1;
         seg_d     = decode(cur_digit);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         pre_cnt  <= '0;
         idx      <= '0;
         snapshot <= '0;
         primed   <= 1'b0;
         seg_q    <= '0;
         an_q     <= '0;
         fs_q     <= 1'b0;
      end else begin
         if (en) begin
            pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
            if (pre_wrap) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         end
         if (load) begin
            snapshot <= bcd_in;
            primed   <= 1'b1;
         end
         fs_q  <= load;
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   // Polarity applied after all logic so reset values invert too.
   assign seg         = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
   assign an          = SEG_ACTIVE_LOW ? ~an_q  : an_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, en, blank_lz, frame_start;
   logic [15:0] bcd_in;
   logic [6:0]  seg;
   logic [3:0]  an;

   logic        clr_l, en_l, blank_l, fs_l;
   logic [15:0] bcd_l;
   logic [6:0]  seg_l;
   logic [3:0]  an_l;

   int n_vec = 0;
   int n_bad = 0;

   bcd_scan_display #(.N_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .clr(clr), .en(en), .bcd_in(bcd_in), .blank_lz(blank_lz),
      .seg(seg), .an(an), .frame_start(frame_start)
   );

   bcd_scan_display #(.N_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .clr(clr_l), .en(en_l), .bcd_in(bcd_l), .blank_lz(blank_l),
      .seg(seg_l), .an(an_l), .frame_start(fs_l)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      clr = 1'b1; en = 1'b1; blank_lz = 1'b0; bcd_in = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_vec++;
         if (seg !== 7'h00 || an !== 4'b0000 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold[%0d]: seg=%h an=%b fs=%b, expected 00 0000 0", i, seg, an, frame_start);
         end
      end
      clr = 1'b0;
      tick;
      n_vec++;
      if (frame_start !== 1'b1 || an !== 4'b0001) begin
         n_bad++;
         $display("FAIL reset_release: fs=%b an=%b, expected 1 0001", frame_start, an);
      end
      tick;
      n_vec++;
      if (frame_start !== 1'b0 || an !== 4'b0001 || seg !== 7'h66) begin
         n_bad++;
         $display("FAIL first_digit: fs=%b an=%b seg=%h, expected 0 0001 66", frame_start, an, seg);
      end
   endtask

   task automatic test_scan;
      logic [31:0] segw;
      int slot;
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      segw = 32'h06_5B_4F_66;
      for (int e = 3; e <= 48; e++) begin
         tick;
         slot = ((e - 1) / 4) % 4;
         ea = 4'b0001 << slot;
         es = segw[8*slot +: 7];
         ef = (e % 16 == 0);
         n_vec++;
         if (an !== ea || seg !== es || frame_start !== ef) begin
            n_bad++;
            $display("FAIL scan e=%0d: an=%b seg=%h fs=%b, expected %b %h %b", e, an, seg, frame_start, ea, es, ef);
         end
      end
   endtask

   task automatic test_tearing;
      logic [31:0] old_w, new_w;
      int slot;
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      old_w = 32'h06_5B_4F_66;
      new_w = 32'h6D_7D_07_7F;
      for (int j = 1; j <= 32; j++) begin
         tick;
         if (j == 5) bcd_in = 16'h5678;
         slot = ((j - 1) % 16) / 4;
         ea = 4'b0001 << slot;
         es = (j <= 16) ? old_w[8*slot +: 7] : new_w[8*slot +: 7];
         ef = (j % 16 == 0);
         n_vec++;
         if (an !== ea || seg !== es || frame_start !== ef) begin
            n_bad++;
            $display("FAIL tearing j=%0d: an=%b seg=%h fs=%b, expected %b %h %b", j, an, seg, frame_start, ea, es, ef);
         end
      end
   endtask

   task automatic test_blanking;
      logic [15:0] next_bcd [4];
      logic [15:0] anw [4];
      logic [31:0] segw [4];
      int slot;
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      next_bcd[0] = 16'h0042; next_bcd[1] = 16'h0000; next_bcd[2] = 16'h00A0; next_bcd[3] = 16'h1234;
      anw[1] = 16'h0021; segw[1] = 32'h0000_665B;
      anw[2] = 16'h0001; segw[2] = 32'h0000_003F;
      anw[3] = 16'h0021; segw[3] = 32'h0000_403F;
      anw[0] = 16'h0000; segw[0] = 32'h0;
      blank_lz = 1'b1;
      for (int f = 0; f < 4; f++) begin
         for (int j = 1; j <= 16; j++) begin
            tick;
            if (j == 2) bcd_in = next_bcd[f];
            if (f > 0) begin
               slot = (j - 1) / 4;
               ea = anw[f][4*slot +: 4];
               es = segw[f][8*slot +: 7];
               ef = (j == 16);
               n_vec++;
               if (an !== ea || seg !== es || frame_start !== ef) begin
                  n_bad++;
                  $display("FAIL blank f=%0d j=%0d: an=%b seg=%h fs=%b, expected %b %h %b", f, j, an, seg, frame_start, ea, es, ef);
               end
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_enable;
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      for (int j = 1; j <= 9; j++) tick;
      n_vec++;
      if (an !== 4'b0100 || seg !== 7'h5B) begin
         n_bad++;
         $display("FAIL pre_disable: an=%b seg=%h, expected 0100 5b", an, seg);
      end
      en = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick;
         n_vec++;
         if (an !== 4'b0000 || seg !== 7'h00 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL disabled[%0d]: an=%b seg=%h fs=%b, expected 0000 00 0", i, an, seg, frame_start);
         end
      end
      en = 1'b1;
      for (int r = 1; r <= 7; r++) begin
         tick;
         ea = (r <= 3) ? 4'b0100 : 4'b1000;
         es = (r <= 3) ? 7'h5B : 7'h06;
         ef = (r == 7);
         n_vec++;
         if (an !== ea || seg !== es || frame_start !== ef) begin
            n_bad++;
            $display("FAIL resume r=%0d: an=%b seg=%h fs=%b, expected %b %h %b", r, an, seg, frame_start, ea, es, ef);
         end
      end
   endtask

   task automatic test_reset_midscan;
      clr = 1'b1;
      tick;
      n_vec++;
      if (an !== 4'b0000 || seg !== 7'h00 || frame_start !== 1'b0) begin
         n_bad++;
         $display("FAIL midscan_clr: an=%b seg=%h fs=%b, expected 0000 00 0", an, seg, frame_start);
      end
      bcd_in = 16'h1239;
      clr = 1'b0;
      tick;
      n_vec++;
      if (frame_start !== 1'b1 || an !== 4'b0001) begin
         n_bad++;
         $display("FAIL midscan_reload: fs=%b an=%b, expected 1 0001", frame_start, an);
      end
      tick;
      n_vec++;
      if (frame_start !== 1'b0 || an !== 4'b0001 || seg !== 7'h6F) begin
         n_bad++;
         $display("FAIL midscan_digit0: fs=%b an=%b seg=%h, expected 0 0001 6f", frame_start, an, seg);
      end
   endtask

   task automatic test_active_low;
      n_vec++;
      if (seg_l !== 7'h7F || an_l !== 4'b1111 || fs_l !== 1'b0) begin
         n_bad++;
         $display("FAIL al_reset: seg=%h an=%b fs=%b, expected 7f 1111 0", seg_l, an_l, fs_l);
      end
      bcd_l = 16'h0008; blank_l = 1'b1; en_l = 1'b1; clr_l = 1'b0;
      tick;
      n_vec++;
      if (fs_l !== 1'b1 || an_l !== 4'b1110) begin
         n_bad++;
         $display("FAIL al_load: fs=%b an=%b, expected 1 1110", fs_l, an_l);
      end
      tick;
      n_vec++;
      if (seg_l !== 7'h00 || an_l !== 4'b1110) begin
         n_bad++;
         $display("FAIL al_digit0: seg=%h an=%b, expected 00 1110", seg_l, an_l);
      end
      for (int i = 3; i <= 5; i++) tick;
      n_vec++;
      if (seg_l !== 7'h7F || an_l !== 4'b1111) begin
         n_bad++;
         $display("FAIL al_blank1: seg=%h an=%b, expected 7f 1111", seg_l, an_l);
      end
   endtask

   initial begin
      clr = 1'b1; en = 1'b0; blank_lz = 1'b0; bcd_in = 16'h0;
      clr_l = 1'b1; en_l = 1'b0; blank_l = 1'b0; bcd_l = 16'h0;
      test_reset;
      test_scan;
      test_tearing;
      test_blanking;
      test_enable;
      test_reset_midscan;
      test_active_low;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
